// File: rtl/mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Holds the FSM state encoding, access size codes and the read latency default.
package mem_pkg;

    localparam int RD_LAT_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RMW_RD  = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    function automatic logic misaligned(input size_t sz, input logic [1:0] off);
        logic r;
        case (sz)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            SZ_ILL:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Little-endian lane logic: extracts and extends sub-word loads,
// and merges sub-word store data into a previously read word.
module mem_lane
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_t       i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_load  = i_word;
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load = {{16{i_signed & w_half[15]}}, w_half};
                o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load  = i_word;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared fetch/data memory port with round-robin grant, sub-word
// load extension and read-modify-write byte/half stores.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic        dm_signed,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        MEM_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_dm;
    logic        r_is_dm;
    logic        r_signed;
    size_t       r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_cnt;

    logic        w_gnt_dm;
    logic        w_gnt_if;
    logic        w_err;
    logic [31:0] w_gaddr;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    logic        w_done_nxt;
    logic        w_isdm_nxt;
    logic        w_mem_w_nxt;
    logic        w_if_done_nxt;
    logic        w_dm_done_nxt;
    logic        w_dm_err_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [31:0] w_if_rdata_nxt;
    logic [31:0] w_dm_rdata_nxt;

    // On a tie the requester that was not served last wins
    assign w_gnt_dm = (r_state == S_IDLE) && dm_req && (!if_req || !r_last_dm);
    assign w_gnt_if = (r_state == S_IDLE) && if_req && !w_gnt_dm;
    assign w_err    = w_gnt_dm && misaligned(size_t'(dm_size), dm_addr[1:0]);
    assign w_gaddr  = w_gnt_dm ? dm_addr : if_addr;

    mem_lane u_lane (
        .i_word   (mem_rdata),
        .i_off    (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last_dm <= 1'b1;
            r_is_dm   <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= SZ_BYTE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
            MEM_w     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            if_done   <= w_if_done_nxt;
            if_rdata  <= w_if_rdata_nxt;
            dm_done   <= w_dm_done_nxt;
            dm_rdata  <= w_dm_rdata_nxt;
            dm_err    <= w_dm_err_nxt;
            MEM_w     <= w_mem_w_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            if (w_gnt_dm || w_gnt_if) begin
                r_last_dm <= w_gnt_dm;
                r_is_dm   <= w_gnt_dm;
                r_signed  <= w_gnt_dm && dm_signed;
                r_size    <= w_gnt_dm ? size_t'(dm_size) : SZ_WORD;
                r_addr    <= w_gaddr;
                r_wdata   <= dm_wdata;
                r_cnt     <= 3'(RD_LAT - 1);
            end else if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_err) begin
                    w_state_nxt = S_DONE;
                end else if (w_gnt_dm && dm_we) begin
                    w_state_nxt = (size_t'(dm_size) == SZ_WORD) ? S_WR : S_RMW_RD;
                end else if (w_gnt_dm || w_gnt_if) begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: if (r_cnt == 3'd0) w_state_nxt = S_DONE;
            S_RMW_RD:  if (r_cnt == 3'd0) w_state_nxt = S_WR;
            S_WR:      w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt      = (w_state_nxt == S_DONE);
        w_isdm_nxt      = (r_state == S_IDLE) ? w_gnt_dm : r_is_dm;
        w_mem_w_nxt     = (w_state_nxt == S_WR);
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_if_rdata_nxt  = if_rdata;
        w_dm_rdata_nxt  = dm_rdata;
        if (w_state_nxt inside {S_RD_WAIT, S_RMW_RD, S_WR}) begin
            w_mem_addr_nxt = (r_state == S_IDLE) ? {w_gaddr[31:2], 2'b00}
                                                 : {r_addr[31:2], 2'b00};
        end
        if (w_mem_w_nxt) begin
            w_mem_wdata_nxt = (r_state == S_IDLE) ? dm_wdata : w_merge;
        end
        if (r_state == S_RD_WAIT && w_state_nxt == S_DONE) begin
            if (r_is_dm) w_dm_rdata_nxt = w_load;
            else         w_if_rdata_nxt = mem_rdata;
        end else if (w_done_nxt && w_isdm_nxt) begin
            w_dm_rdata_nxt = '0;
        end
        w_if_done_nxt = w_done_nxt && !w_isdm_nxt;
        w_dm_done_nxt = w_done_nxt && w_isdm_nxt;
        // Only the misalignment path goes straight from IDLE to DONE
        w_dm_err_nxt  = w_dm_done_nxt && (r_state == S_IDLE);
    end

endmodule
